// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command decoder and single-port byte RAM behind an SPI slave.
// Latency: a read byte appears on tx_data/tx_valid one FETCH cycle after the
// RD_DATA edge is sampled. tx_valid is then held for TX_HOLD cycles. There is
// no backpressure: each rx_valid rising edge is one command.
// Build option: define RAM_ADDR_AUTOINC_EN to post-increment wr_addr and rd_addr.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 9
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  localparam int CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_vld_q;
  logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_SIZE-1:0]   fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [7:0]             mem_q [MEM_DEPTH];

  logic                   accept;
  logic [1:0]             cmd;
  logic [ADDR_SIZE-1:0]   cmd_addr;
  logic                   wr_hit;
  logic                   rd_acc;
  logic [7:0]             rd_byte;

  function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
    return 32'(a) < MEM_DEPTH;
  endfunction

`ifdef RAM_ADDR_AUTOINC_EN
  function automatic logic [ADDR_SIZE-1:0] addr_next(input logic [ADDR_SIZE-1:0] a);
    if (32'(a) >= MEM_DEPTH - 1) return '0;
    return a + 1'b1;
  endfunction
`endif

  assign accept   = rx_valid & ~rx_vld_q;
  assign cmd      = rx_data[9:8];
  assign cmd_addr = rx_data[ADDR_SIZE-1:0];
  assign wr_hit   = accept && (cmd == CMD_WR_DATA);
  // A RD_DATA arriving while a fetch is in progress is dropped.
  assign rd_acc   = accept && (cmd == CMD_RD_DATA) && (state_q != FETCH);
  assign rd_byte  = in_range(fetch_addr_q) ? mem_q[fetch_addr_q] : 8'h00;

  // Edge detector: reset value 1 so a level already high across reset is not a command.
  always_ff @(posedge clk) begin
    if (arst) rx_vld_q <= 1'b1;
    else      rx_vld_q <= rx_valid;
  end

  // Address next-state: explicit loads, latching of the read address, optional post-increment.
  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    fetch_addr_d = fetch_addr_q;
    if (accept) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr_d = cmd_addr;
        CMD_WR_DATA: begin
`ifdef RAM_ADDR_AUTOINC_EN
          wr_addr_d = addr_next(wr_addr_q);
`endif
        end
        CMD_RD_ADDR: rd_addr_d = cmd_addr;
        default: begin
          if (rd_acc) begin
            fetch_addr_d = rd_addr_q;
`ifdef RAM_ADDR_AUTOINC_EN
            rd_addr_d    = addr_next(rd_addr_q);
`endif
          end
        end
      endcase
    end
  end

  // Address registers.
  always_ff @(posedge clk) begin
    if (arst) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      fetch_addr_q <= '0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  // RAM write port; contents survive reset, out-of-range writes are discarded.
  always_ff @(posedge clk) begin
    if (!arst && wr_hit && in_range(wr_addr_q)) mem_q[wr_addr_q] <= rx_data[7:0];
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Next-state logic; a new read during HOLD restarts through FETCH.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = rd_acc ? FETCH : IDLE;
      FETCH:   state_d = HOLD;
      HOLD: begin
        if (rd_acc)            state_d = FETCH;
        else if (cnt_q == '0)  state_d = IDLE;
        else                   state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: load byte on FETCH, hold tx_valid for TX_HOLD cycles, tx_data sticky.
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      FETCH: begin
        tx_data_d  = rd_byte;
        tx_valid_d = 1'b1;
        cnt_d      = CNT_W'(TX_HOLD - 1);
      end
      HOLD: begin
        if (!rd_acc && cnt_q != '0) begin
          tx_valid_d = 1'b1;
          cnt_d      = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: drives on negedge, samples on negedge.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       arst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl dut (
    .clk      (clk),
    .arst     (arst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One rx_valid pulse of a single cycle, followed by a low cycle.
  task automatic send(input logic [1:0] cmd, input logic [7:0] payload);
    @(negedge clk);
    rx_data  = {cmd, payload};
    rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Called at a negedge where tx_valid was seen high; counts the high cycles.
  task automatic count_window(output int n);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (tx_valid) n++;
      else break;
    end
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    int n;
    send(2'b10, addr);
    @(negedge clk);
    rx_data  = {2'b11, 8'h00};
    rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_fetch_low"}, tx_valid, 1'b0);
    rx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld"}, tx_valid, 1'b1);
    check({tag, "_dat"}, tx_data, exp);
    count_window(n);
    check({tag, "_len"}, n, 9);
    check({tag, "_keep"}, tx_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         n;
    logic [7:0] exp2;

    // Reset held two cycles with a RD_DATA level present.
    arst     = 1'b1;
    rx_valid = 1'b1;
    rx_data  = {2'b11, 8'h00};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vld", tx_valid, 1'b0);
    check("rst_dat", tx_data, 8'h00);
    arst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_level_no_cmd", tx_valid, 1'b0);
    end
    rx_valid = 1'b0;

    // Basic write then read.
    send(2'b00, 8'h3C);
    send(2'b01, 8'hA5);
    do_read(8'h3C, 8'hA5, "wr_rd");

    // Restart of a read partway through the hold window.
    send(2'b00, 8'h3D);
    send(2'b01, 8'h5A);
`ifdef RAM_ADDR_AUTOINC_EN
    exp2 = 8'h5A;
`else
    exp2 = 8'hA5;
`endif
    send(2'b10, 8'h3C);
    @(negedge clk);
    rx_data  = {2'b11, 8'h00};
    rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rs_first_vld", tx_valid, 1'b1);
    check("rs_first_dat", tx_data, 8'hA5);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rs_hold_vld", tx_valid, 1'b1);
    end
    rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rs_gap", tx_valid, 1'b0);
    rx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rs_second_vld", tx_valid, 1'b1);
    check("rs_second_dat", tx_data, exp2);
    count_window(n);
    check("rs_second_len", n, 9);

    // Reset in the middle of a hold window.
    send(2'b10, 8'h3C);
    @(negedge clk);
    rx_data  = {2'b11, 8'h00};
    rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mr_pre_vld", tx_valid, 1'b1);
    arst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mr_vld", tx_valid, 1'b0);
    check("mr_dat", tx_data, 8'h00);
    arst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("mr_after_vld", tx_valid, 1'b0);
    end
    do_read(8'h3C, 8'hA5, "mr_mem");

    // Level held five cycles on WR_DATA: a single write.
    send(2'b00, 8'h00);
    @(negedge clk);
    rx_data  = {2'b01, 8'h11};
    rx_valid = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
`ifdef RAM_ADDR_AUTOINC_EN
    send(2'b01, 8'h33);
    do_read(8'h01, 8'h33, "lvl_next");
`endif
    do_read(8'h00, 8'h11, "lvl_mem0");

    // Top address and wrap behaviour.
    send(2'b00, 8'hFF);
    send(2'b01, 8'h01);
    send(2'b01, 8'h02);
`ifdef RAM_ADDR_AUTOINC_EN
    do_read(8'hFF, 8'h01, "wrap_ff");
    do_read(8'h00, 8'h02, "wrap_00");
`else
    do_read(8'hFF, 8'h02, "top_ff");
    do_read(8'h00, 8'h11, "top_00");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
